deser1_to_8: RTL

Serial-to-parallel deserializer: the receive end of the 8-to-1 bit-select serializer. Bits arrive one per valid cycle on a 1-bit line, LSB first, and are steered into slot `k` of an 8-bit word, where `k` is an internal 3-bit slot counter (the demux select). Each completed word is held in an output register and offered downstream on a valid/ready handshake. It sits directly after the serial link and before byte-wide consumers.

---
 rtl/serdes_pkg.sv | 9 +
 rtl/slot_counter.sv | 26 ++
 rtl/deser1_to_8.sv | 87 ++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared types for the 8-bit serial link (serializer and deserializer ends).
package serdes_pkg;

   localparam int SER_DW = 8;

   typedef logic [SER_DW-1:0]         ser_word_t;
   typedef logic [$clog2(SER_DW)-1:0] ser_slot_t;

endpackage

// File: rtl/slot_counter.sv
// Mod-DW slot counter: increments on enable, loads 1 on start-of-frame,
// clears asynchronously. Shared with the serializer's select generator.
module slot_counter #(
   parameter int DW = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   inc,
   input  logic                   load1,
   output logic [$clog2(DW)-1:0]  cnt
);

   localparam int SW = $clog2(DW);

   // Counter register; load-to-1 takes priority over increment, wrap is natural.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load1) begin
         cnt <= SW'(1);
      end else if (inc) begin
         cnt <= cnt + SW'(1);
      end
   end

endmodule

// File: rtl/deser1_to_8.sv
// 1-to-DW deserializer: LSB-first serial bits are steered into slot k of an
// assembly register; completed words go to a one-entry valid/ready output.
module deser1_to_8
   import serdes_pkg::*;
#(
   parameter int DW = SER_DW
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sin,
   input  logic                   sin_vld,
   input  logic                   sof,
   output logic [DW-1:0]          dout,
   output logic                   dout_vld,
   input  logic                   dout_rdy,
   output logic                   overrun,
   output logic [$clog2(DW)-1:0]  slot
);

   localparam int SW = $clog2(DW);

   logic [DW-1:0] asm_q;
   logic [DW-1:0] asm_nxt;
   logic          sof_hit;
   logic          complete;
   logic          load_out;
   logic          drop;

   slot_counter #(
      .DW (DW)
   ) u_slot_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (sin_vld),
      .load1 (sof_hit),
      .cnt   (slot)
   );

   // Next assembly contents and word-completion decisions.
   always_comb begin
      sof_hit  = sin_vld & sof;
      complete = sin_vld & ~sof & (slot == SW'(DW - 1));
      load_out = complete & (~dout_vld | dout_rdy);
      drop     = complete & dout_vld & ~dout_rdy;
      asm_nxt  = asm_q;
      if (sof_hit) begin
         // A new frame discards any partial word.
         asm_nxt    = '0;
         asm_nxt[0] = sin;
      end else if (sin_vld) begin
         asm_nxt[slot] = sin;
      end
   end

   // Assembly register; frozen during gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q <= '0;
      end else begin
         asm_q <= asm_nxt;
      end
   end

   // Output holding register with valid; a same-edge accept and completion
   // replaces the old word with valid held high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout     <= '0;
         dout_vld <= 1'b0;
      end else if (load_out) begin
         dout     <= asm_nxt;
         dout_vld <= 1'b1;
      end else if (dout_vld && dout_rdy) begin
         dout_vld <= 1'b0;
      end
   end

   // Registered one-cycle pulse when a completed word is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun <= 1'b0;
      end else begin
         overrun <= drop;
      end
   end

endmodule
